board_io_ctrl: RTL
==================

Name: board_io_ctrl

Overview:
Parametrised board I/O conditioning block placed between raw board pins (switches, push-buttons, LEDs) and the soft-core's I/O ports.
- Synchronises and debounces N_SW switch inputs and N_BTN button inputs.
- Turns debounced button rising edges into latched, maskable interrupt requests with acknowledge.
- Drives N_LED outputs from a write-enabled output register.

Parameters:
N_SW, 8, number of switch inputs
N_BTN, 2, number of push-button inputs (interrupt sources)
N_LED, 8, number of LED outputs
DEBOUNCE_CYCLES, 32000, consecutive stable cycles required to accept a new input level (1 ms at 32 MHz); legal range >= 2
CNT_W, 15, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
sw_in  input  N_SW  raw switch pins, asynchronous
btn_in  input  N_BTN  raw button pins, asynchronous, high = pressed
sw_out  output  N_SW  debounced switch levels to core input port
btn_state  output  N_BTN  debounced button levels
irq_mask  input  N_BTN  per-button interrupt enable, 1 = enabled
irq_pending  output  N_BTN  latched button-press flags
irq  output  1  interrupt request to core
irq_ack  input  1  single-cycle interrupt acknowledge from core
led_data  input  N_LED  LED value from core output port
led_we  input  1  write strobe for led_data
led_bright  input  8  LED brightness; used only with BOARD_IO_PWM_EN
led_out  output  N_LED  LED pins

Behaviour:
Reset:
- Synchronous, active-high; all flops cleared.
- sw_out, btn_state, irq_pending, irq and led_out are 0 during and after reset.
- Reset asserted mid-debounce or mid-interrupt discards counts and pending flags.

Input path (per sw_in and btn_in bit):
- Each bit passes through a 2-flop synchroniser (s1 -> s2), then an independent debounce counter and a stable register.
- Debounce per bit:
  - s2 == stable: counter <= 0.
  - s2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
- Latency: a clean input step reaches sw_out / btn_state exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples it (±1 for asynchronous alignment).
- Any reversion of s2 to stable before the count completes restarts the count; stable is unchanged.
- sw_out and btn_state equal their stable registers.

Interrupts:
- btn_prev <= btn_state every cycle. rise[i] = btn_state[i] & ~btn_prev[i].
- Pending flag update: irq_pending[i] <= rise[i] | (irq_pending[i] & ~irq_ack).
  - A rise in the same cycle as irq_ack leaves the bit set; new events are never lost.
- Pending flags latch regardless of irq_mask.
- irq = |(irq_pending & irq_mask); combinational from flops, no extra cycle.
- Unmasking a bit that is already pending raises irq in the same cycle.
- irq_ack clears all pending bits, masked or not.
- Button release (falling edge) generates nothing.
- A second press before ack merges into the same pending bit.

LED path:
- led_reg <= led_data when led_we = 1; otherwise it holds.
- led_out follows led_reg one cycle after the led_we edge.
- Width rules: led_data and led_reg are N_LED wide; no truncation.

Optional Feature:
Macro BOARD_IO_PWM_EN.
- Defined:
  - A free-running 8-bit pwm_cnt is reset to 0 and wraps 255 -> 0.
  - led_out = led_reg & {N_LED{pwm_cnt < led_bright}}.
  - led_bright = 0 gives LEDs always off; led_bright = 255 gives on 255 of every 256 cycles.
  - led_bright is sampled combinationally every cycle.
- Not defined: led_out = led_reg, and led_bright is ignored (unconnected internally).

Test Plan:
1. DEBOUNCE_CYCLES=4, rst for 3 cycles, then sw_in=8'hA5 held -> sw_out=8'h00 until edge 6 after the change, then 8'hA5; all outputs 0 throughout reset.
2. DEBOUNCE_CYCLES=4, sw_in[0] toggles 1,0,1,0 every 2 cycles then settles at 1 -> sw_out[0] stays 0 during bounce and rises exactly 6 cycles after the final settle.
3. irq_mask=2'b01, press btn_in[0] -> irq_pending=2'b01 one cycle after btn_state[0] rises, irq=1; pulse irq_ack -> irq_pending=0, irq=0 next cycle.
4. irq_mask=2'b00, press btn_in[1] -> irq_pending=2'b10, irq=0; set irq_mask=2'b10 -> irq=1 same cycle.
5. btn_state[1] rise coincident with irq_ack while irq_pending=2'b01 -> irq_pending=2'b10 afterwards.
6. led_data=8'h3C with led_we pulsed, then led_data=8'hFF with led_we=0 -> led_out=8'h3C. With BOARD_IO_PWM_EN and led_bright=64 -> each LED bit is high exactly 64 of every 256 cycles.

Source files
------------

// File: rtl/board_io_if.sv
// Board I/O bundle between the pin conditioning block and the soft core.
// slave  : the conditioning block (board_io_ctrl)
// master : the core / environment driving it
interface board_io_if #(
  parameter int N_SW  = 8,
  parameter int N_BTN = 2,
  parameter int N_LED = 8
);
  logic [N_SW-1:0]  sw_in;
  logic [N_BTN-1:0] btn_in;
  logic [N_SW-1:0]  sw_out;
  logic [N_BTN-1:0] btn_state;
  logic [N_BTN-1:0] irq_mask;
  logic [N_BTN-1:0] irq_pending;
  logic             irq;
  logic             irq_ack;
  logic [N_LED-1:0] led_data;
  logic             led_we;
  logic [7:0]       led_bright;
  logic [N_LED-1:0] led_out;

  modport slave (
    input  sw_in, btn_in, irq_mask, irq_ack, led_data, led_we, led_bright,
    output sw_out, btn_state, irq_pending, irq, led_out
  );

  modport master (
    output sw_in, btn_in, irq_mask, irq_ack, led_data, led_we, led_bright,
    input  sw_out, btn_state, irq_pending, irq, led_out
  );
endinterface

// File: rtl/board_io_ctrl.sv
// Board I/O conditioning: per-bit 2-flop sync + debounce for switches and
// buttons, button-press interrupt latching with mask/ack, LED output register.
// Optional macro BOARD_IO_PWM_EN adds 8-bit PWM brightness gating on LEDs.

// One conditioned input bit: synchroniser, debounce counter, stable level.
module board_io_deb #(
  parameter int DEBOUNCE_CYCLES = 32000,
  parameter int CNT_W           = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2, stable;
  logic [CNT_W-1:0] cnt;

  // Sync the raw pin, then accept a new level only after it has differed
  // from the stable level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign dout = stable;
endmodule

module board_io_ctrl #(
  parameter int N_SW            = 8,
  parameter int N_BTN           = 2,
  parameter int N_LED           = 8,
  parameter int DEBOUNCE_CYCLES = 32000,
  parameter int CNT_W           = 15
) (
  input logic       clk,
  input logic       rst,
  board_io_if.slave bus
);
  localparam int N_IN = N_SW + N_BTN;

  logic [N_IN-1:0]  raw, deb;
  logic [N_BTN-1:0] btn_prev, rise, pending;
  logic [N_LED-1:0] led_reg;

  // Switches occupy the low lanes, buttons the high lanes.
  assign raw = {bus.btn_in, bus.sw_in};

  board_io_deb #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb [N_IN-1:0] (
    .clk (clk),
    .rst (rst),
    .din (raw),
    .dout(deb)
  );

  assign bus.sw_out    = deb[N_SW-1:0];
  assign bus.btn_state = deb[N_IN-1:N_SW];

  assign rise = bus.btn_state & ~btn_prev;

  // Edge detect on debounced buttons and latch presses; a rise coincident
  // with ack wins so no press is ever dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev <= '0;
      pending  <= '0;
    end else begin
      btn_prev <= bus.btn_state;
      pending  <= rise | (pending & ~{N_BTN{bus.irq_ack}});
    end
  end

  assign bus.irq_pending = pending;
  assign bus.irq         = |(pending & bus.irq_mask);

  // LED output register, written by the core strobe.
  always_ff @(posedge clk) begin
    if (rst)             led_reg <= '0;
    else if (bus.led_we) led_reg <= bus.led_data;
  end

`ifdef BOARD_IO_PWM_EN
  logic [7:0] pwm_cnt;

  // Free-running PWM phase; wraps 255 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign bus.led_out = led_reg & {N_LED{pwm_cnt < bus.led_bright}};
`else
  logic unused_bright;
  assign unused_bright = ^bus.led_bright;
  assign bus.led_out   = led_reg;
`endif
endmodule
